// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM access controller.
//   size_t  : request access size as encoded on req_size
//   state_t : controller FSM states
//   is_misaligned() : natural-alignment check for a size / low address pair
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_CAP,
        WR,
        RESP
    } state_t;

    function automatic logic is_misaligned(input size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_HALF: is_misaligned = lo[0];
            SZ_WORD: is_misaligned = (lo != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sram_lane_merge.sv
// Combinational byte-lane logic between the 32-bit SRAM word and the
// right-aligned CPU data (little-endian lanes).
//   i_old_word   : word as read from SRAM
//   i_new_data   : right-aligned store data
//   i_size       : access size
//   i_lane       : byte address bits [1:0]
//   i_unsigned   : zero-extend loads when 1, sign-extend when 0
//   o_store_word : i_old_word with the addressed lane replaced by i_new_data
//   o_load_word  : addressed lane extracted and extended to 32 bits
module sram_lane_merge
    import sram_ctrl_pkg::*;
(
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_new_data,
    input  size_t       i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_unsigned,
    output logic [31:0] o_store_word,
    output logic [31:0] o_load_word
);

    logic [4:0]  w_byte_sh;
    logic [4:0]  w_half_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte_sh = {i_lane, 3'b000};
    assign w_half_sh = {i_lane[1], 4'b0000};
    assign w_byte    = i_old_word[w_byte_sh +: 8];
    assign w_half    = i_old_word[w_half_sh +: 16];

    always_comb begin
        o_store_word = i_old_word;
        o_load_word  = i_old_word;
        case (i_size)
            SZ_BYTE: begin
                o_store_word[w_byte_sh +: 8] = i_new_data[7:0];
                o_load_word = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            end
            SZ_HALF: begin
                o_store_word[w_half_sh +: 16] = i_new_data[15:0];
                o_load_word = {{16{w_half[15] & ~i_unsigned}}, w_half};
            end
            SZ_WORD: begin
                o_store_word = i_new_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sram_access_ctrl.sv
// CPU-side initiator for the word-wide on-chip SRAM. Accepts one byte/half/
// word load or store at a time over valid/ready, performs read-modify-write
// for sub-word stores, and returns extended load data over valid/ready.
//   HCLK, HRESET         : clock, synchronous active-high reset
//   req_*                : request channel (valid/ready, we, size, unsigned, addr, wdata)
//   resp_*               : response channel (valid/ready, rdata, err)
//   sram_write_enable    : SRAM write strobe, one cycle per store
//   sram_address         : SRAM word index, zero-extended
//   sram_write_data      : SRAM write word
//   sram_read_data       : SRAM read word, valid one cycle after sram_address
// All outputs are registered.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// RD     | SRAM address presented for a read
// RD_CAP | SRAM read data available; load result or merged store word formed
// WR     | sram_write_enable high for one cycle
// RESP   | resp_valid high until resp_ready
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int RAM_SIZE = 1024,
    parameter int ADDR_W   = $clog2(RAM_SIZE)
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        sram_write_enable,
    output logic [31:0] sram_address,
    output logic [31:0] sram_write_data,
    input  logic [31:0] sram_read_data
);

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_req_ready;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_resp_rdata;
    logic              r_sram_we;
    logic [31:0]       r_sram_wdata;
    logic [ADDR_W-1:0] r_word_idx;

    logic              r_we;
    size_t             r_size;
    logic              r_unsigned;
    logic [1:0]        r_lane;
    logic [31:0]       r_wdata;

    size_t             w_req_size;
    logic              w_accept;
    logic              w_oor;
    logic              w_req_err;
    logic              w_word_store;
    logic [31:0]       w_store_word;
    logic [31:0]       w_load_word;

    assign w_req_size   = size_t'(req_size);
    assign w_accept     = (r_state == IDLE) && r_req_ready && req_valid;
    assign w_oor        = ({2'b00, req_addr[31:2]} >= 32'(RAM_SIZE));
    assign w_req_err    = (w_req_size == SZ_ILL)
                        || is_misaligned(w_req_size, req_addr[1:0])
                        || w_oor;
    assign w_word_store = req_we && (w_req_size == SZ_WORD);

    // Lane logic works directly on sram_read_data during RD_CAP.
    sram_lane_merge u_lane_merge (
        .i_old_word   (sram_read_data),
        .i_new_data   (r_wdata),
        .i_size       (r_size),
        .i_lane       (r_lane),
        .i_unsigned   (r_unsigned),
        .o_store_word (w_store_word),
        .o_load_word  (w_load_word)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_req_err) begin
                        w_state_nxt = RESP;
                    end else if (w_word_store) begin
                        w_state_nxt = WR;
                    end else begin
                        w_state_nxt = RD;
                    end
                end
            end
            RD:      w_state_nxt = RD_CAP;
            RD_CAP:  w_state_nxt = r_we ? WR : RESP;
            WR:      w_state_nxt = RESP;
            RESP: begin
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output and request-capture registers, loaded from the current state so
    // every output is a flop.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_sram_we    <= 1'b0;
            r_sram_wdata <= '0;
            r_word_idx   <= '0;
            r_we         <= 1'b0;
            r_size       <= SZ_BYTE;
            r_unsigned   <= 1'b0;
            r_lane       <= 2'b00;
            r_wdata      <= '0;
        end else begin
            r_req_ready <= (w_state_nxt == IDLE);
            r_sram_we   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we       <= req_we;
                        r_size     <= w_req_size;
                        r_unsigned <= req_unsigned;
                        r_lane     <= req_addr[1:0];
                        r_wdata    <= req_wdata;
                        if (w_req_err) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else begin
                            r_word_idx <= req_addr[ADDR_W+1:2];
                            if (w_word_store) begin
                                r_sram_we    <= 1'b1;
                                r_sram_wdata <= req_wdata;
                            end
                        end
                    end
                end
                RD_CAP: begin
                    if (r_we) begin
                        r_sram_we    <= 1'b1;
                        r_sram_wdata <= w_store_word;
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= w_load_word;
                    end
                end
                WR: begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready         = r_req_ready;
    assign resp_valid        = r_resp_valid;
    assign resp_err          = r_resp_err;
    assign resp_rdata        = r_resp_rdata;
    assign sram_write_enable = r_sram_we;
    assign sram_write_data   = r_sram_wdata;
    assign sram_address      = 32'(r_word_idx);

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
- CPU-side initiator for the word-wide on-chip SRAM.
- Accepts byte, halfword and word load/store requests over a valid/ready handshake and drives the SRAM write_enable/Address/write_data port.
- Captures read_data one cycle after the address is presented. Sub-word stores are done by read-modify-write.
- Returns load data, sign- or zero-extended, over a valid/ready response channel. Sits between the load/store unit and SRAM.

Parameters:
- RAM_SIZE, 1024, number of 32-bit SRAM words. Must match the SRAM instance.
- ADDR_W, $clog2(RAM_SIZE), width of the internal word index.

Ports:
- HCLK  input  1  system clock; all state updates on the rising edge
- HRESET  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  misaligned, illegal size, or out of range
- sram_write_enable  output  1  to SRAM write_enable
- sram_address  output  32  word index to SRAM Address; zero-extended from ADDR_W
- sram_write_data  output  32  to SRAM write_data
- sram_read_data  input  32  from SRAM read_data; valid one cycle after sram_address

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, sram_write_enable=0, sram_address=0, sram_write_data=0, state=IDLE. req_ready rises the cycle after HRESET deasserts.
- All outputs are registered.
- States: IDLE, RD, RD_CAP, WR, RESP.
- IDLE: req_ready=1. A request is accepted on req_valid & req_ready at cycle T; all request fields are registered.
- Errors, checked at accept:
  - req_size=11 → error.
  - Half with addr[0]≠0 → error.
  - Word with addr[1:0]≠0 → error.
  - addr[31:2] ≥ RAM_SIZE → error.
  - On error: go to RESP with resp_err=1 and resp_rdata=0. No SRAM access; sram_write_enable stays 0. resp_valid at T+1.
- Word store: WR at T+1 with sram_write_enable=1, sram_address=addr[31:2], sram_write_data=req_wdata. Then RESP; resp_valid at T+2.
- Load: RD at T+1 with sram_address driven. RD_CAP at T+2 samples sram_read_data. Then RESP; resp_valid at T+3.
- Load lane select and extension (little-endian):
  - Byte lane = addr[1:0].
  - Half lane = addr[1].
  - Extend to 32 bits per req_unsigned.
- Sub-word store (read-modify-write):
  - RD at T+1, RD_CAP at T+2.
  - WR at T+3 writes the captured word with only the target byte/half lane replaced by req_wdata[7:0] or req_wdata[15:0].
  - resp_valid at T+4.
- RESP:
  - resp_valid=1, and resp_rdata/resp_err stay stable until resp_ready.
  - On resp_valid & resp_ready: return to IDLE; req_ready=1 next cycle.
  - No request is accepted while in RESP; only one transaction is outstanding at a time.
- sram_write_enable is high for exactly one cycle per store and only in WR.
- HRESET mid-operation: next edge forces IDLE-reset values. sram_write_enable=0 from that edge on. The in-flight transaction is dropped with no response. If HRESET is sampled in the WR cycle, that write still completes at the same edge.
- resp_ready held high: back-to-back word loads run at one per 4 cycles (accept, RD, RD_CAP, RESP).

Decomposition:
- Package sram_ctrl_pkg:
  - size_t enum: SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL.
  - state_t enum: IDLE, RD, RD_CAP, WR, RESP.
- Sub-module sram_lane_merge (combinational):
  - Inputs: old word, new data, size, addr[1:0].
  - Outputs: merged store word; extracted, extended load word.
  - Unit-tested separately.

Test Plan:
- Word store then load: store addr 0x10, data 0xDEADBEEF → sram_write_enable=1 at T+1 with sram_address=4, resp at T+2 err=0. Load 0x10 → resp_rdata=0xDEADBEEF at T+3.
- Byte RMW: word 4 holds 0xDEADBEEF; store byte 0x12 at 0x11 → SRAM receives 0xDEAD12EF at T+3. Signed byte load at 0x13 → 0xFFFFFFDE. Unsigned → 0x000000DE.
- Half loads: word 4 holds 0xDEAD12EF. Signed half at 0x12 → 0xFFFFDEAD. Unsigned half at 0x10 → 0x000012EF.
- Errors, each with resp_err=1 at T+1 and no sram_write_enable pulse:
  - Word load at 0x2.
  - Half store at 0x1.
  - req_size=11.
  - Word store at 0x1000 (word index 1024).
- Backpressure: resp_ready=0 for 5 cycles → resp_valid and resp_rdata stable, req_ready=0 throughout. Accept on the first high cycle.
- Reset during RMW: assert HRESET in the RD_CAP cycle → no SRAM write occurs, no response, req_ready=1 one cycle after release.
